// File: rtl/spbram_ring_fifo_pkg.sv
// Shared types and helpers for the single-port BRAM ring FIFO.
package spbram_ring_fifo_pkg;

  // Fetch FSM state encoding.
  typedef enum logic [0:0] {
    FetchIdle = 1'b0,
    FetchReq  = 1'b1
  } fetch_state_e;

  // Width of the occupancy count: BRAM words plus the holding and output registers.
  function automatic int unsigned count_width(input int unsigned depth_log2);
    return depth_log2 + 2;
  endfunction

  // Word address of a region slot; the pointer arrives already zero-extended.
  function automatic logic [31:0] region_addr(input logic [31:0] base, input logic [31:0] ptr);
    return base + ptr;
  endfunction

endpackage

// File: rtl/spbram_ring_fifo_fetch.sv
// Read side of the ring FIFO: fetch FSM, read pointer and the one-entry output register.
module spbram_ring_fifo_fetch
  import spbram_ring_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  word_avail,  // committed word present, or committing this cycle
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [31:0]           read_addr,
  output logic                  read_valid,
  input  logic                  read_ack,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  fetch_done
);

  fetch_state_e          state_q, state_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  pop_fire;

  assign pop_fire  = valid_q && pop_ready;
  assign pop_data  = data_q;
  assign pop_valid = valid_q;
  // Address is forced to zero while idle so every output reads 0 straight after reset.
  assign read_addr = read_valid ? region_addr(BASE_ADDR, 32'(rd_ptr_q)) : 32'h0;

  // Next state: request a word only when the output register is (or is becoming) free.
  always_comb begin
    state_d    = state_q;
    read_valid = 1'b0;
    fetch_done = 1'b0;
    unique case (state_q)
      FetchIdle: begin
        if (word_avail && (!valid_q || pop_fire)) begin
          state_d = FetchReq;
        end
      end
      FetchReq: begin
        read_valid = 1'b1;
        if (read_ack) begin
          fetch_done = 1'b1;
          state_d    = FetchIdle;
        end
      end
      default: state_d = FetchIdle;
    endcase
  end

  // State, read pointer and output register; a request is entered only with the register empty,
  // so a completing fetch never coincides with a pop.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= FetchIdle;
      rd_ptr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_done) begin
        data_q   <= read_data;
        valid_q  <= 1'b1;
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end else if (pop_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spbram_ring_fifo.sv
// Ring-buffer FIFO in a single-port BRAM region behind the BRAM arbitration controller.
// Optional statistics outputs (oHighWater, oPushStall) under SPBRAM_RING_FIFO_STATS_EN.
module spbram_ring_fifo
  import spbram_ring_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                iClock,
  input  logic                                iReset,
  input  logic [DATA_WIDTH-1:0]               iPushData,
  input  logic                                iPushValid,
  output logic                                oPushReady,
  output logic [DATA_WIDTH-1:0]               oPopData,
  output logic                                oPopValid,
  input  logic                                iPopReady,
  output logic [count_width(DEPTH_LOG2)-1:0]  oCount,
  output logic [31:0]                         oMemWriteAddress,
  output logic [DATA_WIDTH-1:0]               oMemWriteData,
  output logic                                oMemWriteValid,
  input  logic                                iMemWriteAck,
  output logic [31:0]                         oMemReadAddress,
  input  logic [DATA_WIDTH-1:0]               iMemReadData,
  output logic                                oMemReadValid,
  input  logic                                iMemReadAck
`ifdef SPBRAM_RING_FIFO_STATS_EN
  ,
  output logic [count_width(DEPTH_LOG2)-1:0]  oHighWater,
  output logic                                oPushStall
`endif
);

  localparam int unsigned CW = count_width(DEPTH_LOG2);
  localparam int unsigned MW = DEPTH_LOG2 + 1;
  localparam logic [MW-1:0] SLOTS = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  w_pend_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [31:0]           w_addr_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] wr_slot;
  logic [MW-1:0]         mem_cnt_q, mem_cnt_d;
  logic                  w_ack_now;
  logic                  push_ready;
  logic                  push_fire;
  logic                  fetch_done;
  logic                  pop_valid;
  logic [CW-1:0]         count;

  assign w_ack_now = w_pend_q && iMemWriteAck;
  // A pending write already owns a BRAM slot (its ack only moves it into mem_cnt), so both
  // count against capacity; otherwise a push could overwrite an unread word.
  assign push_ready = !iReset && (!w_pend_q || iMemWriteAck)
                      && ((mem_cnt_q + MW'(w_pend_q)) < SLOTS);
  assign push_fire  = iPushValid && push_ready;
  // A push accepted in the ack cycle targets the slot after the one being committed.
  assign wr_slot    = w_ack_now ? wr_ptr_q + 1'b1 : wr_ptr_q;

  assign oPushReady       = push_ready;
  assign oMemWriteValid   = w_pend_q;
  assign oMemWriteAddress = w_addr_q;
  assign oMemWriteData    = w_data_q;
  assign oPopValid        = pop_valid;
  assign count            = CW'(mem_cnt_q) + CW'(w_pend_q) + CW'(pop_valid);
  assign oCount           = count;

  // Committed-word count: write ack adds, completed fetch removes, both together cancel.
  always_comb begin
    mem_cnt_d = mem_cnt_q;
    if (w_ack_now && !fetch_done) begin
      mem_cnt_d = mem_cnt_q + 1'b1;
    end else if (!w_ack_now && fetch_done) begin
      mem_cnt_d = mem_cnt_q - 1'b1;
    end
  end

  // Write stage: holding register, write pointer and committed count.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      w_pend_q  <= 1'b0;
      w_data_q  <= '0;
      w_addr_q  <= '0;
      wr_ptr_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (w_ack_now) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (push_fire) begin
        w_pend_q <= 1'b1;
        w_data_q <= iPushData;
        w_addr_q <= region_addr(BASE_ADDR, 32'(wr_slot));
      end else if (w_ack_now) begin
        w_pend_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_d;
    end
  end

  spbram_ring_fifo_fetch #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (BASE_ADDR),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fetch (
    .iClock     (iClock),
    .iReset     (iReset),
    .word_avail ((mem_cnt_q != '0) || w_ack_now),
    .pop_ready  (iPopReady),
    .pop_data   (oPopData),
    .pop_valid  (pop_valid),
    .read_addr  (oMemReadAddress),
    .read_valid (oMemReadValid),
    .read_ack   (iMemReadAck),
    .read_data  (iMemReadData),
    .fetch_done (fetch_done)
  );

`ifdef SPBRAM_RING_FIFO_STATS_EN
  logic [CW-1:0] high_q;

  assign oHighWater = (count > high_q) ? count : high_q;
  assign oPushStall = !iReset && iPushValid && !push_ready;

  // Running maximum of the occupancy since reset.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      high_q <= '0;
    end else begin
      high_q <= oHighWater;
    end
  end
`endif

endmodule

// File: tb/tb_spbram_ring_fifo.sv
// Self-checking bench for spbram_ring_fifo: queue-based reference model plus directed pins.
module tb_spbram_ring_fifo;

  localparam int unsigned DL   = 2;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] BASE = 32'h100;
  localparam int unsigned CAP  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] push_data;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DL+1:0] count;
  logic [31:0]   write_addr;
  logic [DW-1:0] write_data;
  logic          write_valid;
  logic          write_ack;
  logic [31:0]   read_addr;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          read_ack;
`ifdef SPBRAM_RING_FIFO_STATS_EN
  logic [DL+1:0] high_water;
  logic          push_stall;
`endif

  int tests = 0;
  int fails = 0;

  // Controller model state
  logic          wr_allow, rd_allow, rd_armed;
  logic [DW-1:0] mem [0:1023];

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] pushed[$];
  logic [31:0]   wlog[$];
  int            n_wr = 0, n_rd = 0, n_pop = 0, n_stall = 0, m_hw = 0;
  bit            rst_prev = 0;
  bit            pv_w = 0, pv_r = 0;
  logic [31:0]   pw_addr, pr_addr;
  logic [DW-1:0] pw_data;

  always #5 clk = ~clk;

  spbram_ring_fifo #(
    .DEPTH_LOG2 (DL),
    .BASE_ADDR  (BASE),
    .DATA_WIDTH (DW)
  ) dut (
    .iClock           (clk),
    .iReset           (rst),
    .iPushData        (push_data),
    .iPushValid       (push_valid),
    .oPushReady       (push_ready),
    .oPopData         (pop_data),
    .oPopValid        (pop_valid),
    .iPopReady        (pop_ready),
    .oCount           (count),
    .oMemWriteAddress (write_addr),
    .oMemWriteData    (write_data),
    .oMemWriteValid   (write_valid),
    .iMemWriteAck     (write_ack),
    .oMemReadAddress  (read_addr),
    .iMemReadData     (read_data),
    .oMemReadValid    (read_valid),
    .iMemReadAck      (read_ack)
`ifdef SPBRAM_RING_FIFO_STATS_EN
    ,
    .oHighWater       (high_water),
    .oPushStall       (push_stall)
`endif
  );

  // Controller: writes acked whenever allowed; reads acked one cycle after an unopposed request.
  assign write_ack = write_valid && wr_allow;
  assign read_ack  = read_valid && !write_valid && rd_armed && rd_allow;
  assign read_data = read_ack ? mem[read_addr[9:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) rd_armed <= 1'b0;
    else     rd_armed <= read_valid && !write_valid && !read_ack;
    if (write_valid && write_ack) mem[write_addr[9:0]] <= write_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the queue model, then model update from this cycle's handshakes.
  always @(negedge clk) begin
    if (rst) begin
      if (rst_prev) begin
        check("rst_push_ready", push_ready, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_count", count, 0);
        check("rst_wr_valid", write_valid, 0);
        check("rst_wr_addr", write_addr, 0);
        check("rst_wr_data", write_data, 0);
        check("rst_rd_valid", read_valid, 0);
        check("rst_rd_addr", read_addr, 0);
`ifdef SPBRAM_RING_FIFO_STATS_EN
        check("rst_high_water", high_water, 0);
        check("rst_push_stall", push_stall, 0);
`endif
      end
      q.delete();
      pushed.delete();
      wlog.delete();
      n_wr = 0; n_rd = 0; m_hw = 0;
      pv_w = 0; pv_r = 0;
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      check("count", count, q.size());
      if (q.size() == 0) check("empty_valids", {pop_valid, read_valid}, 0);
      if (q.size() == CAP) check("full_ready", push_ready, 0);
      if (pop_valid && q.size() > 0) check("pop_data", pop_data, q[0]);
      if (pv_w) begin
        check("wr_hold_valid", write_valid, 1);
        check("wr_hold_addr", write_addr, pw_addr);
        check("wr_hold_data", write_data, pw_data);
      end
      if (pv_r) begin
        check("rd_hold_valid", read_valid, 1);
        check("rd_hold_addr", read_addr, pr_addr);
      end
      if (write_valid) begin
        check("wr_addr", write_addr, BASE + 32'(n_wr % 4));
        check("wr_known", n_wr < pushed.size(), 1);
        if (n_wr < pushed.size()) check("wr_data", write_data, pushed[n_wr]);
      end
      if (read_valid) check("rd_addr", read_addr, BASE + 32'(n_rd % 4));
`ifdef SPBRAM_RING_FIFO_STATS_EN
      if (q.size() > m_hw) m_hw = q.size();
      check("high_water", high_water, m_hw);
      check("push_stall", push_stall, push_valid && !push_ready);
      if (push_stall) n_stall++;
`endif
      pv_w = write_valid && !write_ack;
      pw_addr = write_addr;
      pw_data = write_data;
      pv_r = read_valid && !read_ack;
      pr_addr = read_addr;
      if (write_valid && write_ack) begin
        wlog.push_back(write_addr);
        n_wr++;
      end
      if (read_valid && read_ack) n_rd++;
      if (pop_valid && pop_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        n_pop++;
      end
      if (push_valid && push_ready) begin
        q.push_back(push_data);
        pushed.push_back(push_data);
      end
    end
  end

  // Offer up to n words back to back, advancing data on each acceptance.
  task automatic push_burst(input int n, input logic [DW-1:0] base, input int budget,
                            input bit rnd, output int got);
    bit acc;
    got = 0;
    push_valid = 1'b1;
    push_data = rnd ? DW'($urandom) : base;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      acc = push_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        got++;
        push_data = rnd ? DW'($urandom) : base + DW'(got);
      end
    end
    push_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    pop_ready = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (count == 0) break;
      @(posedge clk);
      #1;
      n++;
    end
    check(name, count, 0);
    @(posedge clk);
    #1;
    pop_ready = 1'b0;
  endtask

  task automatic wait_pop(input string name);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (pop_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    check(name, pop_valid, 1);
  endtask

  initial begin
    int n, got, p0, r0;
    bit stream_done;
    rst = 1'b1; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    wr_allow = 1'b1; rd_allow = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: push in cycle 0, output valid in cycle 4
    push_valid = 1'b1; push_data = 32'hA1;
    @(posedge clk); #1;
    push_valid = 1'b0;
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (pop_valid) break;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 4);
    @(posedge clk); #1;

    // Three words held with no pop
    push_burst(2, 32'hA2, 10, 0, got);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abc_pop_valid", pop_valid, 1);
    check("abc_pop_data", pop_data, 32'hA1);
    check("abc_count", count, 3);
    check("abc_model_size", q.size(), 3);
    check("abc_wlog_n", wlog.size(), 3);
    if (wlog.size() >= 3) begin
      check("abc_waddr0", wlog[0], 32'h100);
      check("abc_waddr1", wlog[1], 32'h101);
      check("abc_waddr2", wlog[2], 32'h102);
    end
    @(posedge clk); #1;
    drain("abc_drain");

    // Fill: 5 accepted, 6th waits for a pop
    push_burst(6, 32'hB0, 20, 0, got);
    check("full_accepted", got, 5);
    @(negedge clk);
    check("full_ready_lit", push_ready, 0);
    check("full_count_lit", count, 5);
    @(posedge clk); #1;
    pop_ready = 1'b1;
    @(posedge clk); #1;
    pop_ready = 1'b0;
    push_burst(1, 32'hB5, 20, 0, got);
    check("full_sixth", got, 1);
    drain("full_drain");

    // Random stream with push and pop active, crossing the wrap
    p0 = n_pop;
    stream_done = 0;
    fork
      begin
        push_burst(20, 32'h0, 400, 1, got);
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          wr_allow  = ($urandom_range(0, 3) != 0);
          rd_allow  = ($urandom_range(0, 3) != 0);
          pop_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wr_allow = 1'b1; rd_allow = 1'b1;
    check("stream_accepted", got, 20);
    drain("stream_drain");
    check("stream_popped", n_pop - p0, 20);

    // Read request starved by a pending write for 10 cycles
    pop_ready = 1'b0;
    r0 = n_rd;
    push_valid = 1'b1; push_data = 32'hD0;
    @(posedge clk); #1;
    push_data = 32'hD1;
    @(posedge clk); #1;
    push_valid = 1'b0; wr_allow = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("starve_rd_valid", read_valid, 1);
      check("starve_rd_addr", read_addr, BASE + 32'(r0 % 4));
      check("starve_wr_valid", write_valid, 1);
      @(posedge clk); #1;
    end
    wr_allow = 1'b1;
    wait_pop("starve_done");
    check("starve_data", pop_data, 32'hD0);
    @(posedge clk); #1;
    drain("starve_drain");

    // Reset while a read is outstanding with three words held
    rd_allow = 1'b0;
    push_burst(3, 32'hE0, 10, 0, got);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_rd_valid", read_valid, 1);
    check("pre_rst_count", count, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; rd_allow = 1'b1;
    push_burst(1, 32'hBB, 10, 0, got);
    wait_pop("post_rst_pop");
    check("post_rst_data", pop_data, 32'hBB);
    check("post_rst_wlog_n", wlog.size(), 1);
    if (wlog.size() >= 1) check("post_rst_waddr", wlog[0], 32'h100);
    @(posedge clk); #1;
    drain("post_rst_drain");

`ifdef SPBRAM_RING_FIFO_STATS_EN
    n_stall = 0;
    push_burst(6, 32'hF0, 20, 0, got);
    drain("stats_drain");
    check("stats_high_water", high_water, 5);
    check("stats_stall_seen", n_stall > 0, 1);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
